// File: rtl/bit_serializer_pkg.sv
// Shared types for the serializer and the downstream pattern-detector benches.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_hold_buf.sv
// Single-entry holding register that lets the next word wait while the current one shifts out.
module ser_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             full_next_c,
    output logic             in_ready
);

    // A write on the same edge as a read refills the slot.
    always_comb begin
        full_next_c = full;
        if (rd_en) full_next_c = 1'b0;
        if (wr_en) full_next_c = 1'b1;
    end

    // in_ready follows the next fill state so it never depends on in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
            rd_data  <= '0;
        end else begin
            full     <= full_next_c;
            in_ready <= !full_next_c;
            if (wr_en) rd_data <= wr_data;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one registered serial bit per clock.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned     CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST       = CW'(WIDTH - 1);
    localparam bit              SHIFT_LEFT = (MSB_FIRST == ORDER_MSB_FIRST);

    ser_state_t       state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             a_d, bv_d, fs_d, busy_d;

    logic             xfer, at_last, load;
    logic [WIDTH-1:0] load_word;
    logic             hold_wr, hold_rd, hold_full, hold_full_d;
    logic [WIDTH-1:0] hold_data;

    assign xfer    = in_valid & in_ready;
    assign at_last = (state == SHIFT) && (cnt == LAST);

    ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (hold_wr),
        .wr_data     (in_data),
        .rd_en       (hold_rd),
        .rd_data     (hold_data),
        .full        (hold_full),
        .full_next_c (hold_full_d),
        .in_ready    (in_ready)
    );

    // Next-state: shift, reload from hold or input at the last bit, or fall back to idle.
    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        cnt_d     = cnt;
        a_d       = a;
        bv_d      = bit_valid;
        fs_d      = 1'b0;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        load      = 1'b0;
        load_word = in_data;

        case (state)
            IDLE: begin
                if (xfer) load = 1'b1;
            end
            SHIFT: begin
                if (at_last) begin
                    if (hold_full) begin
                        load      = 1'b1;
                        load_word = hold_data;
                        hold_rd   = 1'b1;
                        hold_wr   = xfer;
                    end else if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        a_d     = IDLE_BIT;
                        bv_d    = 1'b0;
                    end
                end else begin
                    hold_wr = xfer;
                    a_d     = SHIFT_LEFT ? sreg[WIDTH-1] : sreg[0];
                    sreg_d  = SHIFT_LEFT ? (sreg << 1) : (sreg >> 1);
                    cnt_d   = cnt + CW'(1);
                    bv_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A loaded word puts its first bit on the line immediately; sreg keeps the rest.
        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bv_d    = 1'b1;
            fs_d    = 1'b1;
            a_d     = SHIFT_LEFT ? load_word[WIDTH-1] : load_word[0];
            sreg_d  = SHIFT_LEFT ? (load_word << 1) : (load_word >> 1);
        end
    end

    assign busy_d = (state_d == SHIFT) | hold_full_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            a           <= IDLE_BIT;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            sreg        <= sreg_d;
            cnt         <= cnt_d;
            a           <= a_d;
            bit_valid   <= bv_d;
            frame_start <= fs_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances on a shared clock.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data, in_data_l;
    logic       in_valid, in_valid_l;
    logic       in_ready, a, bit_valid, frame_start, busy;
    logic       in_ready_l, a_l, bit_valid_l, frame_start_l, busy_l;

    typedef struct {
        logic b;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .a(a_l), .bit_valid(bit_valid_l), .frame_start(frame_start_l), .busy(busy_l)
    );

    // Expected serial bits of one accepted word.
    task automatic push_word(input logic [7:0] w, input bit msb);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b  = msb ? w[7-i] : w[i];
            e.fs = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if (a !== 1'b0 || bit_valid !== 1'b0 || frame_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: a=%b bv=%b fs=%b rdy=%b busy=%b expected 0 0 0 1 0",
                         c, a, bit_valid, frame_start, in_ready, busy);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0);
            in_data  = (c == 0) ? 8'h99 : 8'h00;
            if (in_valid && in_ready) push_word(8'h99, 1'b1);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (bit_valid !== 1'b1 || a !== e.b || frame_start !== e.fs || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single cyc%0d: a=%b bv=%b fs=%b busy=%b expected a=%b bv=1 fs=%b busy=1",
                             c, a, bit_valid, frame_start, busy, e.b, e.fs);
                end
            end else if (bit_valid !== 1'b0 || a !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single_idle cyc%0d: a=%b bv=%b busy=%b expected 0 0 0", c, a, bit_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        int   idx = 0, seen = 0, gaps = 0, rlow = 0;
        exp_t e;
        words = '{8'h90, 8'h09, 8'hFF};
        for (int c = 0; c < 30; c++) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                in_data  = in_ready ? words[idx] : 8'($urandom);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            if (in_valid && in_ready) begin
                push_word(words[idx], 1'b1);
                idx++;
            end
            @(negedge clk);
            if (bit_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_bit cyc%0d: bv=1 expected bv=0", c);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e.b || frame_start !== e.fs) begin
                        n_fail++;
                        $display("FAIL b2b_bit%0d: a=%b fs=%b expected a=%b fs=%b", seen, a, frame_start, e.b, e.fs);
                    end
                end
                seen++;
            end else if (seen > 0 && exp_q.size() > 0) begin
                gaps++;
            end
            if (!in_ready) rlow++;
        end
        n_checks++;
        if (seen !== 24 || gaps !== 0) begin
            n_fail++;
            $display("FAIL b2b_stream: bits=%0d gaps=%0d expected bits=24 gaps=0", seen, gaps);
        end
        n_checks++;
        if (rlow !== 14) begin
            n_fail++;
            $display("FAIL b2b_ready_low: cycles=%0d expected 14", rlow);
        end
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_lsb_first();
        exp_t e;
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid_l = (c == 0);
            in_data_l  = (c == 0) ? 8'h01 : 8'hFF;
            if (in_valid_l && in_ready_l) push_word(8'h01, 1'b0);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (bit_valid_l !== 1'b1 || a_l !== e.b || frame_start_l !== e.fs) begin
                    n_fail++;
                    $display("FAIL lsb cyc%0d: a=%b bv=%b fs=%b expected a=%b bv=1 fs=%b",
                             c, a_l, bit_valid_l, frame_start_l, e.b, e.fs);
                end
            end else if (bit_valid_l !== 1'b0 || a_l !== 1'b0) begin
                n_fail++;
                $display("FAIL lsb_idle cyc%0d: a=%b bv=%b expected 0 0", c, a_l, bit_valid_l);
            end
        end
        in_valid_l = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 2);
            in_data  = (c == 0) ? 8'hA5 : 8'h3C;
            if (in_valid && in_ready) push_word(in_data, 1'b1);
            @(negedge clk);
            n_checks++;
            e = exp_q.pop_front();
            if (bit_valid !== 1'b1 || a !== e.b || frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL rmid_pre cyc%0d: a=%b bv=%b fs=%b expected a=%b bv=1 fs=%b",
                         c, a, bit_valid, frame_start, e.b, e.fs);
            end
        end
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_hold_full: busy=%b rdy=%b expected busy=1 rdy=0", busy, in_ready);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (a !== 1'b0 || bit_valid !== 1'b0 || frame_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: a=%b bv=%b fs=%b rdy=%b busy=%b expected 0 0 0 1 0",
                     a, bit_valid, frame_start, in_ready, busy);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c == 3);
            in_data  = (c == 3) ? 8'hC3 : 8'h00;
            if (in_valid && in_ready) push_word(8'hC3, 1'b1);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (bit_valid !== 1'b1 || a !== e.b || frame_start !== e.fs) begin
                    n_fail++;
                    $display("FAIL rmid_post cyc%0d: a=%b bv=%b fs=%b expected a=%b bv=1 fs=%b",
                             c, a, bit_valid, frame_start, e.b, e.fs);
                end
            end else if (bit_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_residue cyc%0d: bv=%b busy=%b expected 0 0", c, bit_valid, busy);
            end
        end
    endtask

    task automatic test_last_edge();
        int   seen = 0, gaps = 0;
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c == 0 || c == 8);
            in_data  = (c == 0) ? 8'hF0 : 8'h2D;
            if (c == 8) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last_edge_ready_pre: rdy=%b expected 1", in_ready);
                end
            end
            if (in_valid && in_ready) push_word(in_data, 1'b1);
            @(negedge clk);
            if (bit_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL last_edge_extra cyc%0d: bv=1 expected bv=0", c);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e.b || frame_start !== e.fs) begin
                        n_fail++;
                        $display("FAIL last_edge_bit%0d: a=%b fs=%b expected a=%b fs=%b", seen, a, frame_start, e.b, e.fs);
                    end
                end
                seen++;
            end else if (seen > 0 && exp_q.size() > 0) begin
                gaps++;
            end
            if (c == 8 || c == 9) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last_edge_hold_empty cyc%0d: rdy=%b expected 1", c, in_ready);
                end
            end
        end
        n_checks++;
        if (seen !== 16 || gaps !== 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL last_edge_stream: bits=%0d gaps=%0d pending=%0d expected 16 0 0", seen, gaps, exp_q.size());
        end
        exp_q.delete();
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid();
        test_last_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the serial pattern-detector chain. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on a single serial line. A one-word holding buffer lets back-to-back words stream with no idle gap. Downstream detectors sample the serial line every clock; bit_valid and frame_start qualify it.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first
IDLE_BIT, 0, value driven on a when no word is shifting

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
in_data  in  WIDTH  parallel word
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a word this cycle
a  out  1  serial bit, registered
bit_valid  out  1  a carries a data bit this cycle
frame_start  out  1  a carries the first bit of a word
busy  out  1  shifting or holding buffer occupied

Behaviour:
- Reset (rst=0, async): state=IDLE, a=IDLE_BIT, bit_valid=0, frame_start=0, hold empty, bit count 0, in_ready=1, busy=0. Release is synchronous to the next clk edge.
- Handshake: a word transfers on any rising edge with in_valid=1 and in_ready=1. in_ready = !hold_full (registered, with no combinational path from in_valid).
- States:
  - IDLE: on transfer, load shift register, count=0 and go to SHIFT. The first bit appears on a in the cycle after the transfer edge (1-cycle latency), with bit_valid=1 and frame_start=1.
  - SHIFT: each edge advances one bit and increments count. frame_start=1 only when count=0.
  - Last-bit edge (count=WIDTH-1):
    - If hold is full, load from hold and restart at count=0. Hold becomes empty unless a transfer also occurs this edge, in which case the new word enters hold.
    - Else if a transfer occurs this edge, load the word directly into the shift register.
    - Else go to IDLE with a=IDLE_BIT and bit_valid=0.
  - Transfer while SHIFT and not at the last bit: the word goes to hold, hold_full=1, and in_ready drops next cycle.
- Throughput: continuous in_valid gives an unbroken bit stream (WIDTH bits per word, zero gap cycles). in_ready toggles so that exactly one word is accepted per WIDTH cycles in steady state.
- Bit order: MSB_FIRST=1 emits in_data[WIDTH-1] down to [0]; MSB_FIRST=0 emits [0] up to [WIDTH-1].
- Counter width is $clog2(WIDTH) and wraps to 0 only via reload.
- busy = (state==SHIFT) | hold_full.
- Reset mid-word: the partial word and the hold word are discarded. There is no partial output after release.
- in_data is sampled only on a transfer edge. Changes while in_ready=0 are ignored.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and a BIT_ORDER constant pair (MSB_FIRST/LSB_FIRST), reused by the downstream detector benches.
- One natural sub-module, ser_hold_buf: the single-entry holding register with full flag and in_ready generation. The shift, count and FSM logic stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1 with in_valid=0 -> a=0, bit_valid=0, in_ready=1, busy=0 throughout.
- Single word 8'h99, MSB_FIRST=1: transfer at edge k -> a=1,0,0,1,1,0,0,1 on cycles k+1..k+8, frame_start only at k+1, bit_valid drops at k+9.
- Back-to-back 8'h90, 8'h09, 8'hFF with in_valid held high -> 24 contiguous valid bits 10010000_00001001_11111111, no gap, frame_start at bits 0/8/16, in_ready low while hold is full.
- MSB_FIRST=0, word 8'h01 -> first emitted bit is 1, followed by seven 0s.
- Reset asserted at bit 4 of 8'hA5 with hold containing 8'h3C -> outputs go to reset values immediately, and the first word after release is emitted cleanly with no A5/3C residue.
- Transfer on the last-bit edge with hold empty -> new word starts at the next cycle with zero gap and hold stays empty.
